// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared encodings for the intersection phase scheduler:
// phase codes offered to the light FSM and scheduler states.
package traffic_phase_scheduler_pkg;

    typedef enum logic [1:0] {
        PHASE_PRIMARY   = 2'd0,
        PHASE_SECONDARY = 2'd1,
        PHASE_PED_WALK  = 2'd2,
        PHASE_EMERGENCY = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        SCHED_IDLE   = 2'd0,
        SCHED_SELECT = 2'd1,
        SCHED_OFFER  = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic ped;
        logic starved;
        logic sec;
    } pending_t;

    // Fixed priority: emergency, starved secondary, pedestrian, secondary.
    function automatic phase_t select_phase(
        input logic emergency,
        input logic starved,
        input logic ped,
        input logic sec
    );
        phase_t p;
        if (emergency)
            p = PHASE_EMERGENCY;
        else if (starved)
            p = PHASE_SECONDARY;
        else if (ped)
            p = PHASE_PED_WALK;
        else if (sec)
            p = PHASE_SECONDARY;
        else
            p = PHASE_PRIMARY;
        return p;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_debouncer.sv
// Two-flop synchronizer plus stability counter for a raw field input;
// pulses rose on the cycle the debounced level goes high.
module input_debouncer #(
    parameter int DEBOUNCE_COUNT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic rose
);

    localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_COUNT - 1);

    logic          sync1;
    logic          synced;
    logic          level;
    logic [CW-1:0] cnt;
    logic          done;

    // Counter only runs while the synced input disagrees with the level.
    assign done = (synced != level) && (cnt == LAST);
    assign rose = done && synced;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            synced <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1  <= raw;
            synced <= sync1;
            if (synced == level) begin
                cnt <= '0;
            end else if (done) begin
                level <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Collects sensor, pedestrian and emergency demand and offers one
// phase per decision to the light FSM over a valid/ready handshake.
module traffic_phase_scheduler
    import traffic_phase_scheduler_pkg::*;
#(
    parameter int DEBOUNCE_COUNT = 16,
    parameter int MAX_WAIT_COUNT = 1000,
    parameter int WAIT_BITS      = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       secondaryRoadSensor,
    input  logic       pedButtonPrimary,
    input  logic       pedButtonSecondary,
    input  logic       emergencyPreempt,
    input  logic       phaseReady,
    output logic [1:0] phaseGrant,
    output logic       grantValid,
    output logic [2:0] pendingReq
);

    localparam logic [WAIT_BITS-1:0] WAIT_MAX = WAIT_BITS'(MAX_WAIT_COUNT);

    sched_state_t         state;
    sched_state_t         state_n;
    phase_t               grant;
    logic                 load_grant;
    logic                 xfer;

    logic                 sec_rise;
    logic                 sec_req;
    logic                 ped_req;
    logic [WAIT_BITS-1:0] wait_cnt;
    logic                 starved;
    logic                 clr_sec;
    logic                 clr_ped;

    logic                 pp_s1, pp_s2, pp_d;
    logic                 ps_s1, ps_s2, ps_d;
    logic                 emg_s1, emg_s2;
    logic                 ped_rise;
    pending_t             pending;

    input_debouncer #(
        .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
    ) u_sensor (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (secondaryRoadSensor),
        .rose   (sec_rise)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pp_s1  <= 1'b0;
            pp_s2  <= 1'b0;
            pp_d   <= 1'b0;
            ps_s1  <= 1'b0;
            ps_s2  <= 1'b0;
            ps_d   <= 1'b0;
            emg_s1 <= 1'b0;
            emg_s2 <= 1'b0;
        end else begin
            pp_s1  <= pedButtonPrimary;
            pp_s2  <= pp_s1;
            pp_d   <= pp_s2;
            ps_s1  <= pedButtonSecondary;
            ps_s2  <= ps_s1;
            ps_d   <= ps_s2;
            emg_s1 <= emergencyPreempt;
            emg_s2 <= emg_s1;
        end
    end

    assign ped_rise = (pp_s2 & ~pp_d) | (ps_s2 & ~ps_d);

    assign xfer    = (state == SCHED_OFFER) && phaseReady;
    assign clr_sec = xfer && (grant == PHASE_SECONDARY);
    assign clr_ped = xfer && (grant == PHASE_PED_WALK);
    assign starved = (wait_cnt == WAIT_MAX);

    // A new request arriving in the transfer cycle survives the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec_req <= 1'b0;
            ped_req <= 1'b0;
        end else begin
            sec_req <= sec_rise | (sec_req & ~clr_sec);
            ped_req <= ped_rise | (ped_req & ~clr_ped);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (!sec_req || clr_sec) begin
            wait_cnt <= '0;
        end else if (!starved) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SCHED_IDLE;
            grant <= PHASE_PRIMARY;
        end else begin
            state <= state_n;
            if (load_grant)
                grant <= select_phase(emg_s2, starved, ped_req, sec_req);
        end
    end

    always_comb begin
        state_n    = state;
        grantValid = 1'b0;
        load_grant = 1'b0;
        unique case (state)
            SCHED_IDLE: begin
                state_n = SCHED_SELECT;
            end
            SCHED_SELECT: begin
                load_grant = 1'b1;
                state_n    = SCHED_OFFER;
            end
            SCHED_OFFER: begin
                grantValid = 1'b1;
                if (phaseReady)
                    state_n = SCHED_IDLE;
                else if (emg_s2 && grant != PHASE_EMERGENCY)
                    state_n = SCHED_SELECT;
            end
            default: begin
                state_n = SCHED_IDLE;
            end
        endcase
    end

    assign pending.ped     = ped_req;
    assign pending.starved = starved;
    assign pending.sec     = sec_req;

    assign phaseGrant = grant;
    assign pendingReq = pending;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scenario bench for traffic_phase_scheduler: expected grants are queued
// as stimulus is applied and popped as each handshake completes.
module tb_traffic_phase_scheduler;

    logic       clk;
    logic       reset_n;
    logic       secondaryRoadSensor;
    logic       pedButtonPrimary;
    logic       pedButtonSecondary;
    logic       emergencyPreempt;
    logic       phaseReady;
    logic [1:0] phaseGrant;
    logic       grantValid;
    logic [2:0] pendingReq;

    int         vectors;
    int         miscompares;
    logic [1:0] sb[$];

    traffic_phase_scheduler #(
        .DEBOUNCE_COUNT(16),
        .MAX_WAIT_COUNT(1000),
        .WAIT_BITS     (10)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .secondaryRoadSensor(secondaryRoadSensor),
        .pedButtonPrimary   (pedButtonPrimary),
        .pedButtonSecondary (pedButtonSecondary),
        .emergencyPreempt   (emergencyPreempt),
        .phaseReady         (phaseReady),
        .phaseGrant         (phaseGrant),
        .grantValid         (grantValid),
        .pendingReq         (pendingReq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset(input logic ready);
        reset_n             = 1'b0;
        secondaryRoadSensor = 1'b0;
        pedButtonPrimary    = 1'b0;
        pedButtonSecondary  = 1'b0;
        emergencyPreempt    = 1'b0;
        phaseReady          = ready;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic wait_xfer(input int budget, output logic [1:0] g,
                             output bit ok);
        ok = 1'b0;
        g  = 2'b00;
        for (int i = 0; i < budget && !ok; i++) begin
            if (grantValid === 1'b1 && phaseReady === 1'b1) begin
                g  = phaseGrant;
                ok = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic drain(input string name);
        logic [1:0] exp, got;
        bit ok;
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            wait_xfer(20, got, ok);
            vectors++;
            if (!ok || got !== exp) begin
                miscompares++;
                $display("FAIL %s: grant %0d (handshake seen=%0b) expected %0d",
                         name, got, ok, exp);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        phaseReady = 1'b1;
        secondaryRoadSensor = 1'b0;
        pedButtonPrimary = 1'b0;
        pedButtonSecondary = 1'b0;
        emergencyPreempt = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (grantValid !== 1'b0 || phaseGrant !== 2'd0 || pendingReq !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_values: valid=%b grant=%0d pend=%b expected 0/0/000",
                     grantValid, phaseGrant, pendingReq);
        end
        @(negedge clk);
        reset_n = 1'b1;
        // Cycle 1 is the release cycle; offers expected on cycles 3, 6, 9.
        for (int k = 0; k < 9; k++) begin
            vectors++;
            if (grantValid !== ((k % 3) == 2)) begin
                miscompares++;
                $display("FAIL idle_cadence: cycle %0d valid=%b expected %b",
                         k + 1, grantValid, ((k % 3) == 2));
            end
            if (grantValid === 1'b1) begin
                vectors++;
                if (phaseGrant !== 2'd0) begin
                    miscompares++;
                    $display("FAIL idle_grant: cycle %0d grant=%0d expected 0",
                             k + 1, phaseGrant);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_secondary();
        do_reset(1'b0);
        repeat (4) @(negedge clk);
        secondaryRoadSensor = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 17 || i == 18) begin
                vectors++;
                if (pendingReq[0] !== (i == 18)) begin
                    miscompares++;
                    $display("FAIL sec_latency: edge %0d secReq=%b expected %b",
                             i, pendingReq[0], (i == 18));
                end
            end
        end
        secondaryRoadSensor = 1'b0;
        sb.push_back(2'd0);
        sb.push_back(2'd1);
        phaseReady = 1'b1;
        drain("sec_order");
        vectors++;
        if (pendingReq[0] !== 1'b0 || grantValid !== 1'b0) begin
            miscompares++;
            $display("FAIL sec_clear: secReq=%b valid=%b expected 0/0",
                     pendingReq[0], grantValid);
        end
        phaseReady = 1'b0;
    endtask

    task automatic test_glitch();
        do_reset(1'b1);
        @(negedge clk);
        secondaryRoadSensor = 1'b1;
        repeat (10) @(negedge clk);
        secondaryRoadSensor = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (grantValid === 1'b1) begin
                vectors++;
                if (phaseGrant !== 2'd0) begin
                    miscompares++;
                    $display("FAIL glitch_grant: grant=%0d expected 0", phaseGrant);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (pendingReq !== 3'b000) begin
            miscompares++;
            $display("FAIL glitch_pending: pend=%b expected 000", pendingReq);
        end
    endtask

    task automatic test_ped_and_sec();
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        secondaryRoadSensor = 1'b1;
        pedButtonPrimary    = 1'b1;
        repeat (3) @(negedge clk);
        pedButtonPrimary = 1'b0;
        repeat (20) @(negedge clk);
        secondaryRoadSensor = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (pendingReq !== 3'b101) begin
            miscompares++;
            $display("FAIL ped_sec_pending: pend=%b expected 101", pendingReq);
        end
        sb.push_back(2'd0);
        sb.push_back(2'd2);
        sb.push_back(2'd1);
        sb.push_back(2'd0);
        phaseReady = 1'b1;
        drain("ped_sec_order");
        vectors++;
        if (pendingReq !== 3'b000) begin
            miscompares++;
            $display("FAIL ped_sec_clear: pend=%b expected 000", pendingReq);
        end
        phaseReady = 1'b0;
    endtask

    task automatic test_starvation();
        do_reset(1'b0);
        repeat (2) @(negedge clk);
        secondaryRoadSensor = 1'b1;
        repeat (20) @(negedge clk);
        secondaryRoadSensor = 1'b0;
        repeat (480) @(negedge clk);
        vectors++;
        if (pendingReq !== 3'b001) begin
            miscompares++;
            $display("FAIL starve_early: pend=%b expected 001", pendingReq);
        end
        repeat (530) @(negedge clk);
        vectors++;
        if (pendingReq !== 3'b011) begin
            miscompares++;
            $display("FAIL starve_set: pend=%b expected 011", pendingReq);
        end
        pedButtonSecondary = 1'b1;
        repeat (3) @(negedge clk);
        pedButtonSecondary = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (pendingReq !== 3'b111) begin
            miscompares++;
            $display("FAIL starve_ped_pending: pend=%b expected 111", pendingReq);
        end
        sb.push_back(2'd0);
        sb.push_back(2'd1);
        sb.push_back(2'd2);
        sb.push_back(2'd0);
        phaseReady = 1'b1;
        drain("starve_order");
        vectors++;
        if (pendingReq !== 3'b000) begin
            miscompares++;
            $display("FAIL starve_clear: pend=%b expected 000", pendingReq);
        end
        phaseReady = 1'b0;
    endtask

    task automatic test_emergency();
        logic [1:0] exp_g[4];
        logic       exp_v[4];
        exp_v = '{1'b1, 1'b1, 1'b0, 1'b1};
        exp_g = '{2'd0, 2'd0, 2'd0, 2'd3};
        do_reset(1'b0);
        repeat (4) @(negedge clk);
        vectors++;
        if (grantValid !== 1'b1 || phaseGrant !== 2'd0) begin
            miscompares++;
            $display("FAIL emg_pre_offer: valid=%b grant=%0d expected 1/0",
                     grantValid, phaseGrant);
        end
        emergencyPreempt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (grantValid !== exp_v[i] ||
                (exp_v[i] && phaseGrant !== exp_g[i])) begin
                miscompares++;
                $display("FAIL emg_withdraw: step %0d valid=%b grant=%0d expected %b/%0d",
                         i + 1, grantValid, phaseGrant, exp_v[i], exp_g[i]);
            end
        end
        sb.push_back(2'd3);
        phaseReady = 1'b1;
        drain("emg_accept");
        phaseReady = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (grantValid !== 1'b1 || phaseGrant !== 2'd3) begin
            miscompares++;
            $display("FAIL emg_reoffer: valid=%b grant=%0d expected 1/3",
                     grantValid, phaseGrant);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (grantValid !== 1'b0 || pendingReq !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset: valid=%b pend=%b expected 0/000",
                     grantValid, pendingReq);
        end
        emergencyPreempt = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        secondaryRoadSensor = 1'b0;
        pedButtonPrimary    = 1'b0;
        pedButtonSecondary  = 1'b0;
        emergencyPreempt    = 1'b0;
        phaseReady          = 1'b0;
        test_reset();
        test_secondary();
        test_glitch();
        test_ped_and_sec();
        test_starvation();
        test_emergency();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
